// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end and its RAM partner.
// No logic; state encoding, default widths and RAM command codes only.
// Optional frame error reporting is controlled by SPI_FRAME_ERR_EN in spi_slave_if.
package spi_pkg;

    // FSM encoding, fixed so the wrapper and bench can read it consistently
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam int WORD_W_DEF = 10;
    localparam int TX_W_DEF   = 8;

    // Command codes carried in word bits [9:8]; decoded by the RAM, not here
    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    // True for the states that shift in a command/data word
    function automatic logic is_rx_state(input state_e s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave: MOSI -> 10-bit rx word with 1-cycle rx_valid; RAM read byte -> MISO MSB-first.
// Latency: rx_valid on the edge sampling bit 0; MISO bit 7 on the edge tx_valid is sampled.
// No backpressure: RAM must accept every rx_valid; waits indefinitely for tx_valid. SPI_FRAME_ERR_EN adds frame_err.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int TX_W   = TX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [TX_W-1:0]   tx_data,
    input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int CW  = $clog2(WORD_W + 1);
    localparam int TCW = $clog2(TX_W + 1);
    // cnt_q counts word bits already received; CNT_LAST means this edge samples bit 0
    localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_W - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WORD_W);
    // tx_cnt_q counts MISO bits already driven; 0 means still waiting for the RAM
    localparam logic [TCW-1:0] TX_DONE  = TCW'(TX_W);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORD_W-2:0]   shreg_q, shreg_d;
    logic                rd_seen_q, rd_seen_d;
    logic [TX_W-1:0]     tx_sh_q, tx_sh_d;
    logic [TCW-1:0]      tx_cnt_q, tx_cnt_d;
    logic                miso_q, miso_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
`ifdef SPI_FRAME_ERR_EN
    logic                err_q, err_d;
`endif

    // Next-state: routing, shift-in, shift-out, and SS_n abort override
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rd_seen_d  = rd_seen_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`ifdef SPI_FRAME_ERR_EN
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (!SS_n) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD: begin
                // Bit 9 alone plus rd_seen picks the route; bit 8 is left to the RAM
                shreg_d    = '0;
                shreg_d[0] = MOSI;
                cnt_d      = CW'(1);
                if (!MOSI) begin
                    state_d = WRITE;
                end else if (rd_seen_q) begin
                    state_d = READ_DATA;
                end else begin
                    state_d = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (cnt_q != CNT_FULL) begin
                    shreg_d = {shreg_q[WORD_W-3:0], MOSI};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d  = {shreg_q, MOSI};
                        rx_valid_d = 1'b1;
                        if (state_q == READ_ADD) begin
                            rd_seen_d = 1'b1;
                        end
                        if (state_q == READ_DATA) begin
                            rd_seen_d = 1'b0;
                        end
                    end
                end else if (state_q == READ_DATA) begin
                    if (tx_cnt_q == '0) begin
                        if (tx_valid) begin
                            tx_sh_d  = tx_data;
                            miso_d   = tx_data[TX_W-1];
                            tx_cnt_d = TCW'(1);
                        end
                    end else if (tx_cnt_q != TX_DONE) begin
                        miso_d   = tx_sh_q[TX_W-2];
                        tx_sh_d  = {tx_sh_q[TX_W-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + TCW'(1);
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // Deselect wins over everything except a word finishing on this same edge
        if (SS_n && (state_q != IDLE)) begin
`ifdef SPI_FRAME_ERR_EN
            if ((is_rx_state(state_q) && (cnt_q != '0) && (cnt_q < CNT_LAST)) ||
                ((state_q == READ_DATA) && (tx_cnt_q != TX_DONE))) begin
                err_d = 1'b1;
            end
`endif
            state_d  = IDLE;
            cnt_d    = '0;
            shreg_d  = '0;
            tx_sh_d  = '0;
            tx_cnt_d = '0;
            miso_d   = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame with no rx_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            rd_seen_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rd_seen_q  <= rd_seen_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef SPI_FRAME_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
    assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: directed frames, rx words checked by a scoreboard monitor.
// MISO and frame_err are checked inline against hand-computed bytes.
// Build with SPI_FRAME_ERR_EN defined to also cover frame_err.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] last_rx = 10'h000;

    spi_slave_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rx_valid pops one expected word; rx_data must hold otherwise
    always @(posedge clk) begin
        #1;
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got rx_data %0h with no word expected at %0t", rx_data, $time);
            end else begin
                last_rx = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(last_rx));
            end
        end else begin
            check("rx_hold", 32'(rx_data), 32'(last_rx));
        end
    end

    // Full frame: select, CHK_CMD edge, then 10 bits MSB-first; optionally deselect on bit 0
    task automatic frame_word(input logic [9:0] w, input logic [9:0] expw, input bit ss_on_last);
        exp_q.push_back(expw);
        SS_n = 1'b0;
        MOSI = w[9];
        step();
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            if (i == 0 && ss_on_last) SS_n = 1'b1;
            step();
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
    endtask

    task automatic pulse_tx(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // After tx load edge: MISO shows bits 7..0 on consecutive cycles, then idles low
    task automatic check_miso_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) begin
            check("miso_bit", 32'(MISO), 32'(b[7-k]));
            step();
        end
        check("miso_after", 32'(MISO), 32'h0);
        step();
        check("miso_after2", 32'(MISO), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        step();
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
`ifdef SPI_FRAME_ERR_EN
        check("rst_frame_err", 32'(frame_err), 32'h0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Write address, with a stray tx_valid that must be ignored
        frame_word({WR_ADDR, 8'hFF}, 10'h0FF, 1'b0);
        pulse_tx(8'hFF);
        check("miso_write_ignore", 32'(MISO), 32'h0);
        end_frame();

        // Write data
        frame_word({WR_DATA, 8'h03}, 10'h103, 1'b0);
        end_frame();

        // Read address; tx_valid in READ_ADD must not drive MISO
        frame_word({RD_ADDR, 8'hFE}, 10'h2FE, 1'b0);
        pulse_tx(8'hFF);
        check("miso_readadd_ignore", 32'(MISO), 32'h0);
        end_frame();

        // Read data with one-cycle RAM latency
        frame_word({RD_DATA, 8'h00}, 10'h300, 1'b0);
        pulse_tx(8'hA5);
        check_miso_byte(8'hA5);
        end_frame();
`ifdef SPI_FRAME_ERR_EN
        check("err_clean_read", 32'(frame_err), 32'h0);
`endif

        // Read pair with a slow RAM: MISO stays low while waiting
        frame_word({RD_ADDR, 8'h12}, 10'h212, 1'b0);
        end_frame();
        frame_word({RD_DATA, 8'h55}, 10'h355, 1'b0);
        step();
        step();
        check("miso_wait", 32'(MISO), 32'h0);
        pulse_tx(8'h3C);
        check_miso_byte(8'h3C);
        end_frame();

        // Deselect on the same edge as bit 0: word still completes
        frame_word({WR_ADDR, 8'hAA}, 10'h0AA, 1'b1);
        step();
`ifdef SPI_FRAME_ERR_EN
        check("err_same_edge", 32'(frame_err), 32'h0);
`endif
        frame_word({WR_DATA, 8'hC3}, 10'h1C3, 1'b0);
        end_frame();

        // Abort after 5 bits of 01_0101_0101: nothing delivered
        begin
            logic [9:0] aw;
            aw = 10'b01_0101_0101;
            SS_n = 1'b0;
            step();
            for (int i = 9; i >= 5; i--) begin
                MOSI = aw[i];
                step();
            end
            end_frame();
            check("miso_abort", 32'(MISO), 32'h0);
`ifdef SPI_FRAME_ERR_EN
            check("err_abort", 32'(frame_err), 32'h1);
`endif
        end
        frame_word({WR_DATA, 8'h55}, 10'h155, 1'b0);
        end_frame();

        // Reset while MISO presents bit 3 of an all-ones byte
        frame_word({RD_ADDR, 8'hAB}, 10'h2AB, 1'b0);
        end_frame();
        frame_word({RD_DATA, 8'hCD}, 10'h3CD, 1'b0);
        pulse_tx(8'hFF);
        for (int k = 0; k < 5; k++) begin
            check("miso_pre_reset", 32'(MISO), 32'h1);
            if (k < 4) step();
        end
        #2;
        rst_n = 1'b0;
        last_rx = 10'h000;
        #1;
        check("rst_mid_miso", 32'(MISO), 32'h0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_mid_rx_data", 32'(rx_data), 32'h0);
`ifdef SPI_FRAME_ERR_EN
        check("rst_mid_err", 32'(frame_err), 32'h0);
`endif
        SS_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // rd_addr_seen cleared: a leading 1 goes to READ_ADD, the next one to READ_DATA
        frame_word({RD_ADDR, 8'h01}, 10'h201, 1'b0);
        pulse_tx(8'hFF);
        check("miso_post_reset_readadd", 32'(MISO), 32'h0);
        step();
        check("miso_post_reset_readadd2", 32'(MISO), 32'h0);
        end_frame();
        frame_word({RD_DATA, 8'h01}, 10'h301, 1'b0);
        pulse_tx(8'h96);
        check_miso_byte(8'h96);
        end_frame();
        step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front end that sits directly upstream of the single-port RAM.
- Deserialises MOSI into 10-bit command/data words and hands them to the RAM on rx_data/rx_valid.
- Accepts the RAM's read byte on tx_data/tx_valid and serialises it MSB-first on MISO.
- Clocked on the system clock, which is also the SPI bit clock. One bit per rising clk edge while SS_n is low.

Parameters:
- WORD_W, 10, width of the received word: 2 command bits plus 8 address/data bits.
- TX_W, 8, width of the read byte returned on MISO.

Ports:
- clk  in  1  system/SPI clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  slave select, active low; frames a transaction
- MOSI  in  1  serial data in, sampled on rising clk
- MISO  out  1  serial data out, registered
- rx_data  out  WORD_W  last completed received word
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  TX_W  read byte from RAM
- tx_valid  in  1  tx_data valid strobe from RAM

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, MISO=0, rx_data=0, rx_valid=0.
  - bit counter=0, rd_addr_seen flag=0.
  - Reset asserted mid-frame aborts immediately; no rx_valid is produced.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay. MISO=0.
- CHK_CMD:
  - MOSI sampled this edge is word bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 with rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 with rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift the next 9 MOSI bits MSB-first, bits 8..0.
  - On the edge sampling bit 0, rx_data takes the full 10-bit word and rx_valid=1 for exactly one cycle.
  - rx_data holds its value until the next completed word.
- After a WRITE word: stay in WRITE, ignoring MOSI, until SS_n=1.
- After a READ_ADD word: rd_addr_seen=1 on the same edge as rx_valid; stay in READ_ADD until SS_n=1.
- READ_DATA:
  - After its word completes, rd_addr_seen=0 on the same edge as rx_valid, then wait for tx_valid.
  - On the edge tx_valid=1 is sampled, load tx_data; MISO=tx_data[7] from that edge.
  - Shift out the remaining 7 bits on the next 7 edges.
  - After bit 0, MISO=0 until SS_n=1.
  - Expected RAM latency: tx_valid 1 cycle after rx_valid. Any latency is accepted; the block waits indefinitely.
- tx_valid outside the READ_DATA wait phase is ignored.
- SS_n=1 in any non-IDLE state:
  - Next state is IDLE; counters and shifter cleared; MISO=0.
  - A partial word is discarded with no rx_valid; rd_addr_seen is unchanged.
- SS_n rising on the same edge as bit 0: the word completes (rx_valid=1) and the state returns to IDLE.
- Command bits are passed through unmodified. The RAM decodes din[9:8].
- The FSM decides routing only on bit 9 plus rd_addr_seen. Bit 8 is not checked.

Optional Feature:
- Macro SPI_FRAME_ERR_EN.
- Defined: adds output frame_err (1 bit, registered, reset 0).
  - Set when SS_n rises with a word partially received: counter between 1 and 9, or CHK_CMD already sampled.
  - Also set when SS_n rises during READ_DATA before the 8 MISO bits complete.
  - Sticky until rst_n.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package spi_pkg:
  - State encoding constants IDLE=3'd0, CHK_CMD=3'd1, WRITE=3'd2, READ_ADD=3'd3, READ_DATA=3'd4.
  - Defaults for WORD_W and TX_W.
  - Command codes WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11, for the bench and the RAM.
- No sub-module. Single FSM plus shift-in and shift-out registers.
- The SPI slave and RAM are instantiated together by the system wrapper.

Test Plan:
- Write address: SS_n=0, MOSI 00_1111_1111 over 10 cycles after CHK_CMD -> rx_data=10'h0FF, rx_valid one cycle; no MISO activity.
- Write data: MOSI 01_0000_0011 -> rx_data=10'h103, rx_valid one pulse. SS_n=1 -> IDLE next cycle.
- Read address: MOSI 10_1111_1110 -> rx_data=10'h2FE, rd_addr_seen=1.
- Read data: MOSI 11_0000_0000, then tx_valid=1 with tx_data=8'hA5 one cycle after rx_valid -> rx_data=10'h300; MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_seen=0.
- Abort: SS_n=1 after 5 bits of MOSI 01_0101_0101 -> no rx_valid; state IDLE; frame_err=1 when SPI_FRAME_ERR_EN is defined.
- Reset mid-read: rst_n=0 during MISO bit 3 -> MISO=0, rx_valid=0, rd_addr_seen=0 immediately. The next frame starting with 1 routes to READ_ADD.
